// File: rtl/beat_tempo_detector_pkg.sv
// Shared types and helpers for the beat/tempo detector and its divider.
package tempo_pkg;

  typedef enum logic {ARMED, HOLD} det_state_e;

  typedef enum logic [1:0] {D_IDLE, D_RUN, D_DONE} div_state_e;

  // Samples between two beats at a tempo given in tenths of BPM: rate*60*10/bpm_x10.
  function automatic int unsigned interval_for(input int unsigned sample_rate,
                                               input int unsigned bpm_x10);
    return (sample_rate * 600) / bpm_x10;
  endfunction

endpackage

// File: rtl/beat_tempo_detector_if.sv
// Sample-stream input and tempo output bundle of the beat/tempo detector.
interface beat_tempo_detector_if #(
  parameter int DATA_BITS = 21,
  parameter int BPM_BITS  = 12
);
  logic                 data_in_ready;
  logic [DATA_BITS-1:0] data_in;
  logic [DATA_BITS-1:0] threshold;
  logic                 beat_pulse;
  logic [BPM_BITS-1:0]  bpm_x10;
  logic                 bpm_valid;
  logic                 busy;

  modport master (
    output data_in_ready, data_in, threshold,
    input  beat_pulse, bpm_x10, bpm_valid, busy
  );

  modport slave (
    input  data_in_ready, data_in, threshold,
    output beat_pulse, bpm_x10, bpm_valid, busy
  );
endinterface

// File: rtl/beat_tempo_detector_seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock; quotient is held until the next result.
module seq_divider
  import tempo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);
  localparam int STEP_W = $clog2(WIDTH);

  div_state_e        state, state_next;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  rem, quo, dvs;
  logic [WIDTH:0]    trial, diff;

  always_comb begin
    state_next = state;
    case (state)
      D_IDLE:  if (start) state_next = D_RUN;
      D_RUN:   if (step == STEP_W'(WIDTH - 1)) state_next = D_DONE;
      D_DONE:  state_next = D_IDLE;
      default: state_next = D_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= D_IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= (state == D_DONE);
    end
  end

  assign busy  = (state != D_IDLE);
  // A set top bit of diff is the borrow: the shifted remainder is below the divisor.
  assign trial = {rem, quo[WIDTH-1]};
  assign diff  = trial - {1'b0, dvs};

  always_ff @(posedge clk) begin
    case (state)
      D_IDLE: if (start) begin
        rem  <= '0;
        quo  <= dividend;
        dvs  <= divisor;
        step <= '0;
      end
      D_RUN: begin
        step <= step + 1'b1;
        if (!diff[WIDTH]) begin
          rem <= diff[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], 1'b1};
        end else begin
          rem <= trial[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], 1'b0};
        end
      end
      D_DONE:  quotient <= quo;
      default: ;
    endcase
  end

endmodule

// File: rtl/beat_tempo_detector.sv
// Threshold/hysteresis beat detector; converts beat-to-beat interval into tempo (tenths of BPM).
module beat_tempo_detector
  import tempo_pkg::*;
#(
  parameter int          DATA_BITS     = 21,
  parameter int unsigned SAMPLE_RATE   = 44100,
  parameter int          BPM_BITS      = 12,
  parameter int unsigned MIN_BPM_X10   = 600,
  parameter int unsigned MAX_BPM_X10   = 2000,
  parameter int          INTERVAL_BITS = 18,
  parameter int          HYST_SHIFT    = 3
) (
  input logic                  clk,
  input logic                  rst,
  beat_tempo_detector_if.slave bus
);
  localparam int unsigned NUMERATOR    = SAMPLE_RATE * 600;
  localparam int unsigned MIN_INTERVAL = interval_for(SAMPLE_RATE, MAX_BPM_X10);
  localparam int unsigned MAX_INTERVAL = interval_for(SAMPLE_RATE, MIN_BPM_X10);
  localparam int          DIV_BITS     = 32;
  localparam logic [INTERVAL_BITS-1:0] SAT_COUNT = INTERVAL_BITS'(MAX_INTERVAL + 1);

  function automatic logic [BPM_BITS-1:0] clamp_bpm(input logic [DIV_BITS-1:0] q);
    if (q < DIV_BITS'(MIN_BPM_X10)) return BPM_BITS'(MIN_BPM_X10);
    if (q > DIV_BITS'(MAX_BPM_X10)) return BPM_BITS'(MAX_BPM_X10);
    return q[BPM_BITS-1:0];
  endfunction

  det_state_e               state, state_next;
  logic [INTERVAL_BITS-1:0] count, interval_now;
  logic [DATA_BITS-1:0]     release_level;
  logic                     above, below_release, beat_accept, have_prev;
  logic                     div_start, div_busy, div_done;
  logic [DIV_BITS-1:0]      div_q;
  logic                     beat_pulse_p0, vld_p1;
  logic [BPM_BITS-1:0]      bpm_p1;

  assign release_level = bus.threshold - (bus.threshold >> HYST_SHIFT);
  assign above         = (bus.data_in >= bus.threshold);
  assign below_release = (bus.data_in < release_level);
  // Interval including the current strobe, so beats N samples apart measure N.
  assign interval_now  = (count == SAT_COUNT) ? count : count + 1'b1;

  always_comb begin
    state_next  = state;
    beat_accept = 1'b0;
    if (bus.data_in_ready) begin
      case (state)
        ARMED: if (above && interval_now >= INTERVAL_BITS'(MIN_INTERVAL)) begin
          state_next  = HOLD;
          beat_accept = 1'b1;
        end
        HOLD:    if (below_release) state_next = ARMED;
        default: state_next = ARMED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= ARMED;
    else      state <= state_next;
  end

  assign div_start = beat_accept && have_prev && !div_busy &&
                     (interval_now <= INTERVAL_BITS'(MAX_INTERVAL));

  // Stage p0: interval bookkeeping and beat pulse on the accepting strobe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count         <= '0;
      have_prev     <= 1'b0;
      beat_pulse_p0 <= 1'b0;
    end else begin
      beat_pulse_p0 <= beat_accept;
      if (bus.data_in_ready) begin
        if (beat_accept) begin
          count     <= '0;
          have_prev <= 1'b1;
        end else begin
          count <= interval_now;
          if (interval_now == SAT_COUNT) have_prev <= 1'b0;
        end
      end
    end
  end

  seq_divider #(.WIDTH(DIV_BITS)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (DIV_BITS'(NUMERATOR)),
    .divisor  (DIV_BITS'(interval_now)),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_q)
  );

  // Stage p1: clamp and publish the finished quotient.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p1 <= 1'b0;
      bpm_p1 <= '0;
    end else begin
      vld_p1 <= div_done;
      if (div_done) bpm_p1 <= clamp_bpm(div_q);
    end
  end

  assign bus.beat_pulse = beat_pulse_p0;
  assign bus.bpm_x10    = bpm_p1;
  assign bus.bpm_valid  = vld_p1;
  assign bus.busy       = div_busy;

endmodule
